instruction_fetch_queue: RTL and testbench



---
 rtl/instruction_fetch_queue.sv | 101 ++++++++++
 tb/tb_instruction_fetch_queue.sv | 305 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch_queue.sv
// instruction_fetch_queue: latency-tolerant fetch front end.
// Credit-limited sequential requests, in-order responses, PC-tagged FIFO.
module instruction_fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        mem_req_valid,
  output logic [31:0] mem_req_addr,
  input  logic        mem_req_ready,
  input  logic        mem_resp_valid,
  input  logic [31:0] mem_resp_data,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [31:0]   r_fetch_pc;
  logic [31:0]   r_resp_pc;
  logic [CW-1:0] r_count;
  logic [CW-1:0] r_inflight;
  logic [CW-1:0] r_drop;
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [31:0]   r_pc_mem   [DEPTH];
  logic [31:0]   r_word_mem [DEPTH];

  logic        w_credit;
  logic        w_acc;
  logic        w_resp;
  logic        w_keep;
  logic        w_pop;
  logic [CW:0] w_used;

  // buffered plus in-flight work bounds new requests
  assign w_used   = {1'b0, r_count} + {1'b0, r_inflight};
  assign w_credit = w_used < (CW+1)'(DEPTH);

  assign mem_req_valid = !rst && !redirect && w_credit;
  assign mem_req_addr  = r_fetch_pc;

  assign w_acc  = mem_req_valid && mem_req_ready;
  assign w_resp = mem_resp_valid && (r_inflight != '0);
  assign w_keep = w_resp && (r_drop == '0);

  assign instr_valid = (r_count != '0);
  assign instr       = r_word_mem[r_rd_ptr];
  assign instr_pc    = r_pc_mem[r_rd_ptr];
  assign w_pop       = instr_valid && instr_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_pc <= RESET_PC;
      r_resp_pc  <= RESET_PC;
      r_count    <= '0;
      r_inflight <= '0;
      r_drop     <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
    end else if (redirect) begin
      // every response still owed belongs to the old path
      r_fetch_pc <= redirect_pc;
      r_resp_pc  <= redirect_pc;
      r_count    <= '0;
      r_rd_ptr   <= '0;
      r_wr_ptr   <= '0;
      r_inflight <= r_inflight - CW'(w_resp);
      r_drop     <= r_inflight - CW'(w_resp);
    end else begin
      if (w_acc) begin
        r_fetch_pc <= r_fetch_pc + 32'd4;
      end
      if (w_keep) begin
        r_wr_ptr  <= r_wr_ptr + AW'(1);
        r_resp_pc <= r_resp_pc + 32'd4;
      end
      if (w_resp && (r_drop != '0)) begin
        r_drop <= r_drop - CW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      r_inflight <= r_inflight + CW'(w_acc) - CW'(w_resp);
      r_count    <= r_count + CW'(w_keep) - CW'(w_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && !redirect && w_keep) begin
      r_pc_mem[r_wr_ptr]   <= r_resp_pc;
      r_word_mem[r_wr_ptr] <= mem_resp_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch_queue.sv
// tb_instruction_fetch_queue: random-latency memory plus queue-based
// reference model, checked every cycle, with directed scenarios.
module tb_instruction_fetch_queue;
  localparam int          DEPTH    = 4;
  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        mem_req_valid;
  logic [31:0] mem_req_addr;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  always #5 clk = ~clk;

  instruction_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(RESET_PC)) dut (
    .clk(clk),
    .rst(rst),
    .redirect(redirect),
    .redirect_pc(redirect_pc),
    .mem_req_valid(mem_req_valid),
    .mem_req_addr(mem_req_addr),
    .mem_req_ready(mem_req_ready),
    .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data),
    .instr_valid(instr_valid),
    .instr(instr),
    .instr_pc(instr_pc),
    .instr_ready(instr_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // memory: accepted requests answered in order after a random latency
  logic [31:0] mq_addr[$];
  int          mq_due[$];
  int          cyc      = 0;
  int          last_due = 0;
  int          lat_min  = 1;
  int          lat_max  = 1;
  int          lat;

  // reference model: the specification's state held as plain queues/ints
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] w;
  } ent_t;
  ent_t        m_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_resp;
  int          m_infl;
  int          m_drop;
  bit          m_known = 0;
  bit          m_acc;
  bit          m_rsp;
  bit          m_pop;

  logic [31:0] pops[$];
  logic [31:0] accs[$];

  function automatic bit m_reqv();
    return !rst && !redirect && (m_q.size() + m_infl < DEPTH);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      mq_addr.delete();
      mq_due.delete();
      last_due = cyc;
    end else begin
      if (mem_resp_valid && mq_addr.size() > 0) begin
        void'(mq_addr.pop_front());
        void'(mq_due.pop_front());
      end
      if (mem_req_valid && mem_req_ready) begin
        lat = $urandom_range(lat_max, lat_min);
        if (cyc + lat > last_due) last_due = cyc + lat;
        else last_due = last_due + 1;
        mq_addr.push_back(mem_req_addr);
        mq_due.push_back(last_due);
        accs.push_back(mem_req_addr);
      end
      if (!redirect && instr_valid && instr_ready) pops.push_back(instr_pc);
    end

    if (rst) begin
      m_q.delete();
      m_fetch = RESET_PC;
      m_resp  = RESET_PC;
      m_infl  = 0;
      m_drop  = 0;
      m_known = 1;
    end else if (m_known) begin
      m_rsp = mem_resp_valid && (m_infl > 0);
      if (redirect) begin
        m_q.delete();
        m_fetch = redirect_pc;
        m_resp  = redirect_pc;
        m_infl  = m_infl - int'(m_rsp);
        m_drop  = m_infl;
      end else begin
        m_acc = (m_q.size() + m_infl < DEPTH) && mem_req_ready;
        m_pop = (m_q.size() > 0) && instr_ready;
        if (m_pop) void'(m_q.pop_front());
        if (m_rsp) begin
          if (m_drop > 0) m_drop--;
          else begin
            m_q.push_back({m_resp, mem_resp_data});
            m_resp = m_resp + 32'd4;
          end
        end
        if (m_acc) m_fetch = m_fetch + 32'd4;
        m_infl = m_infl + int'(m_acc) - int'(m_rsp);
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (m_known) begin
      chk("mem_req_valid", 32'(mem_req_valid), 32'(m_reqv()));
      chk("mem_req_addr", mem_req_addr, m_fetch);
      chk("instr_valid", 32'(instr_valid), 32'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("instr_pc", instr_pc, m_q[0].pc);
        chk("instr", instr, m_q[0].w);
        chk("instr_vs_mem", instr, mem_word(instr_pc));
      end
      chk("inflight_bound", 32'(mq_addr.size() <= DEPTH), 32'd1);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    redirect = 1'b0;
    mem_resp_valid = (mq_addr.size() > 0) && (mq_due[0] <= cyc);
    mem_resp_data  = mem_resp_valid ? mem_word(mq_addr[0]) : $urandom;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input int lmin, input int lmax);
    lat_min = lmin;
    lat_max = lmax;
    rst = 1'b1;
    tick();
    #1;
    chk("rst_req_valid", 32'(mem_req_valid), 32'd0);
    chk("rst_instr_valid", 32'(instr_valid), 32'd0);
    tick();
    rst = 1'b0;
    pops.delete();
    accs.delete();
    #1;
    chk("rel_req_valid", 32'(mem_req_valid), 32'd1);
    chk("rel_req_addr", mem_req_addr, RESET_PC);
  endtask

  int first_v;

  initial begin
    rst = 1'b1;
    redirect = 1'b0;
    redirect_pc = '0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = '0;
    instr_ready = 1'b0;

    // latency 1, consumer always ready
    mem_req_ready = 1'b1;
    instr_ready = 1'b1;
    do_reset(1, 1);
    first_v = -1;
    for (int k = 0; k < 12; k++) begin
      #1;
      if (instr_valid && first_v < 0) first_v = k;
      tick();
    end
    chk("first_valid_cycle", first_v, 2);
    chk("t1_acc_count", 32'(accs.size() >= 8), 32'd1);
    chk("t1_pop_count", 32'(pops.size() >= 6), 32'd1);
    for (int k = 0; k < 8 && k < accs.size(); k++)
      chk("t1_req_addr", accs[k], 32'(4 * k));
    for (int k = 0; k < 6 && k < pops.size(); k++)
      chk("t1_instr_pc", pops[k], 32'(4 * k));

    // consumer stalled, latency 2
    instr_ready = 1'b0;
    do_reset(2, 2);
    run(12);
    #1;
    chk("t2_accepted", accs.size(), 4);
    chk("t2_req_blocked", 32'(mem_req_valid), 32'd0);
    chk("t2_full", 32'(instr_valid), 32'd1);
    instr_ready = 1'b1;
    run(12);
    chk("t2_pop_count", 32'(pops.size() >= 5), 32'd1);
    for (int k = 0; k < 4 && k < pops.size(); k++)
      chk("t2_drain_pc", pops[k], 32'(4 * k));
    chk("t2_acc_count", 32'(accs.size() >= 5), 32'd1);
    if (accs.size() >= 5) chk("t2_resume_addr", accs[4], 32'd16);

    // redirect with three requests in flight, latency 3
    do_reset(3, 3);
    run(3);
    #1;
    chk("t3_inflight", accs.size(), 3);
    chk("t3_resp_now", 32'(mem_resp_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h100;
    #1;
    chk("t3_req_withdrawn", 32'(mem_req_valid), 32'd0);
    tick();
    #1;
    chk("t3_flushed", 32'(instr_valid), 32'd0);
    run(15);
    chk("t3_pop_count", 32'(pops.size() >= 2), 32'd1);
    if (pops.size() >= 2) begin
      chk("t3_first_pc", pops[0], 32'h100);
      chk("t3_second_pc", pops[1], 32'h104);
    end
    if (accs.size() >= 4) chk("t3_redir_addr", accs[3], 32'h100);

    // redirect coinciding with a response and a pop, latency 2
    do_reset(2, 2);
    run(5);
    #1;
    chk("t4_valid_before", 32'(instr_valid), 32'd1);
    chk("t4_pc_before", instr_pc, 32'd8);
    chk("t4_resp_now", 32'(mem_resp_valid), 32'd1);
    redirect = 1'b1;
    redirect_pc = 32'h200;
    tick();
    #1;
    chk("t4_flushed", 32'(instr_valid), 32'd0);
    run(15);
    chk("t4_pop_count", 32'(pops.size() >= 3), 32'd1);
    if (pops.size() >= 3) begin
      chk("t4_pop0", pops[0], 32'd0);
      chk("t4_pop1", pops[1], 32'd4);
      chk("t4_pop2", pops[2], 32'h200);
    end
    if (accs.size() >= 6) chk("t4_redir_addr", accs[5], 32'h200);

    // address wrap then mid-stream reset
    do_reset(1, 1);
    redirect = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    run(10);
    chk("t5_pop_count", 32'(pops.size() >= 4), 32'd1);
    if (pops.size() >= 4) begin
      chk("t5_pop0", pops[0], 32'hFFFF_FFF8);
      chk("t5_pop1", pops[1], 32'hFFFF_FFFC);
      chk("t5_wrap", pops[2], 32'h0000_0000);
      chk("t5_pop3", pops[3], 32'h0000_0004);
    end
    do_reset(1, 1);
    run(5);
    chk("t5_rst_addr0", accs[0], RESET_PC);
    chk("t5_rst_addr1", accs[1], RESET_PC + 32'd4);

    // random latency, handshakes, redirects and occasional reset
    do_reset(1, 6);
    for (int i = 0; i < 10000; i++) begin
      mem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 99) < 3) begin
        redirect = 1'b1;
        redirect_pc = $urandom & 32'hFFFF_FFFC;
      end
      if ($urandom_range(0, 2999) == 0) do_reset(1, 6);
      else tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
